// File: rtl/tick_pkg.sv
// Shared types and constants for the game-tick scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tick_pkg;

   localparam int DEF_PER_W = 16;
   localparam int STATE_W   = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      STEP  = 2'd3
   } state_t;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: programmable period, counter and registered strobe.
// Latency: tick is high the cycle after the base event that completes a period.
// Backpressure: none; the strobe is fire-and-forget, consumers must sample it.
module tick_channel
   import tick_pkg::*;
#(
   parameter int PER_W = DEF_PER_W
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             base_ev,
   input  logic             we,
   input  logic [PER_W-1:0] wdata,
   output logic             tick
);

   logic [PER_W-1:0] period_q;
   logic [PER_W-1:0] cnt_q;
   logic             last;

   // Counter has reached the final base tick of the period.
   assign last = (cnt_q == period_q - PER_W'(1));

   // Period register and counter; a write restarts the count and beats a same-cycle base event.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         period_q <= '0;
         cnt_q    <= '0;
      end else if (we) begin
         period_q <= wdata;
         cnt_q    <= '0;
      end else if (base_ev && (period_q != '0)) begin
         if (last) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + PER_W'(1);
         end
      end
   end

   // Registered one-cycle strobe at the end of each period.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         tick <= 1'b0;
      end else begin
         tick <= !we && base_ev && (period_q != '0) && last;
      end
   end

endmodule

// File: rtl/tick_scheduler.sv
// Game-tick scheduler: prescaled base tick plus NUM_CH programmable enable strobes, with run/pause/step control.
// Latency: base_tick/tick are registered, one cycle after the base event; first base_tick PRESCALE cycles after entering RUN.
// Backpressure: none; strobes are single-cycle and are not held for slow consumers.
module tick_scheduler
   import tick_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int PRESCALE = 50000,
   parameter int PER_W    = DEF_PER_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              run,
   input  logic              step,
   input  logic              cfg_we,
   input  logic [2:0]        cfg_ch,
   input  logic [PER_W-1:0]  cfg_period,
   output logic              base_tick,
   output logic [NUM_CH-1:0] tick,
   output logic [1:0]        state
);

   localparam int              PS_W    = $clog2(PRESCALE);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   state_t          state_q;
   state_t          state_d;
   logic [PS_W-1:0] pre_q;
   logic            base_ev;

   // FSM state register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and base event; run beats step when leaving PAUSE.
   always_comb begin
      state_d = state_q;
      base_ev = 1'b0;
      case (state_q)
         IDLE: begin
            if (run) state_d = RUN;
         end
         RUN: begin
            base_ev = (pre_q == PS_LAST);
            if (!run) state_d = PAUSE;
         end
         PAUSE: begin
            if (run) begin
               state_d = RUN;
            end else if (step) begin
               state_d = STEP;
            end
         end
         STEP: begin
            base_ev = 1'b1;
            state_d = PAUSE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Prescaler: cleared in IDLE, counts in RUN, frozen otherwise so a resume finishes the partial period.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pre_q <= '0;
      end else begin
         case (state_q)
            IDLE:    pre_q <= '0;
            RUN:     pre_q <= (pre_q == PS_LAST) ? '0 : pre_q + PS_W'(1);
            default: pre_q <= pre_q;
         endcase
      end
   end

   // Registered base tick strobe.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         base_tick <= 1'b0;
      end else begin
         base_tick <= base_ev;
      end
   end

   assign state = state_q;

   // One channel per consumer; out-of-range cfg_ch values match no channel.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tick_channel #(
         .PER_W (PER_W)
      ) u_ch (
         .clk     (clk),
         .clr     (clr),
         .base_ev (base_ev),
         .we      (cfg_we && (cfg_ch == 3'(i))),
         .wdata   (cfg_period),
         .tick    (tick[i])
      );
   end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with PRESCALE=4 and four channels.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_tick_scheduler;

   localparam int NUM_CH   = 4;
   localparam int PRESCALE = 4;
   localparam int PER_W    = 16;

   logic              clk = 1'b0;
   logic              clr;
   logic              run;
   logic              step;
   logic              cfg_we;
   logic [2:0]        cfg_ch;
   logic [PER_W-1:0]  cfg_period;
   logic              base_tick;
   logic [NUM_CH-1:0] tick;
   logic [1:0]        state;

   int n_cmp  = 0;
   int n_fail = 0;

   // Pause/step scenario, one entry per clock: inputs applied, outputs expected after that edge.
   bit         ps_run  [25] = '{1,1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,1,1};
   bit         ps_step [25] = '{0,0,0,0,0,0,0,0,0,0,1,0,0,1,1,1,0,0,1,0,0,0,0,0,0};
   logic [1:0] ps_st   [25] = '{1,1,1,1,1,1,2,2,2,2,3,2,2,3,2,3,2,2,1,1,1,1,1,1,1};
   bit         ps_bt   [25] = '{0,0,0,0,1,0,0,0,0,0,0,1,0,0,1,0,1,0,0,0,1,0,0,0,1};

   tick_scheduler #(
      .NUM_CH   (NUM_CH),
      .PRESCALE (PRESCALE),
      .PER_W    (PER_W)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .run        (run),
      .step       (step),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .base_tick  (base_tick),
      .tick       (tick),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr        = 1'b1;
      run        = 1'b0;
      step       = 1'b0;
      cfg_we     = 1'b0;
      cfg_ch     = 3'd0;
      cfg_period = '0;
      step_clk();
      step_clk();
      clr = 1'b0;
   endtask

   task automatic cfg_write(input logic [2:0] ch, input logic [PER_W-1:0] per);
      cfg_we     = 1'b1;
      cfg_ch     = ch;
      cfg_period = per;
      step_clk();
      cfg_we     = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({base_tick, tick, state} !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_state: got bt=%b tick=%b st=%0d, want all 0", base_tick, tick, state);
      end
      cfg_write(3'd2, 16'd1);
      run = 1'b1;
      for (int j = 0; j < 5; j++) step_clk();
      // j=4: base_tick and tick[2] are high; clear mid-cycle
      #2;
      clr = 1'b1;
      #1;
      n_cmp++;
      if ({base_tick, tick, state} !== 7'd0) begin
         n_fail++;
         $display("FAIL async_clear: got bt=%b tick=%b st=%0d, want all 0", base_tick, tick, state);
      end
      run = 1'b0;
      step_clk();
      clr = 1'b0;
      for (int j = 0; j < 10; j++) begin
         step_clk();
         n_cmp++;
         if ({base_tick, tick, state} !== 7'd0) begin
            n_fail++;
            $display("FAIL idle_quiet[%0d]: got bt=%b tick=%b st=%0d, want all 0", j, base_tick, tick, state);
         end
      end
   endtask

   task automatic test_basic_rate();
      do_reset();
      cfg_write(3'd0, 16'd3);
      run = 1'b1;
      for (int j = 0; j < 26; j++) begin
         logic exp_bt;
         logic exp_t0;
         step_clk();
         exp_bt = (j > 0) && (j % 4 == 0);
         exp_t0 = (j > 0) && (j % 12 == 0);
         n_cmp++;
         if (state !== 2'd1 || base_tick !== exp_bt || tick !== {3'b000, exp_t0}) begin
            n_fail++;
            $display("FAIL basic_rate[%0d]: got st=%0d bt=%b tick=%b, want st=1 bt=%b tick=000%b",
                     j, state, base_tick, tick, exp_bt, exp_t0);
         end
      end
      run = 1'b0;
   endtask

   task automatic test_pause_step();
      do_reset();
      cfg_write(3'd2, 16'd1);
      for (int k = 0; k < 25; k++) begin
         logic [3:0] exp_tick;
         run  = ps_run[k];
         step = ps_step[k];
         step_clk();
         exp_tick = ps_bt[k] ? 4'b0100 : 4'b0000;
         n_cmp++;
         if (state !== ps_st[k] || base_tick !== ps_bt[k] || tick !== exp_tick) begin
            n_fail++;
            $display("FAIL pause_step[%0d]: got st=%0d bt=%b tick=%b, want st=%0d bt=%b tick=%b",
                     k, state, base_tick, tick, ps_st[k], ps_bt[k], exp_tick);
         end
      end
      run  = 1'b0;
      step = 1'b0;
   endtask

   task automatic test_disable_period1();
      do_reset();
      cfg_write(3'd1, 16'd0);
      cfg_write(3'd2, 16'd1);
      cfg_write(3'd3, 16'd2);
      run = 1'b1;
      for (int j = 0; j < 21; j++) begin
         logic       exp_bt;
         logic [3:0] exp_tick;
         step_clk();
         exp_bt   = (j > 0) && (j % 4 == 0);
         exp_tick = {(j > 0) && (j % 8 == 0), exp_bt, 1'b0, 1'b0};
         n_cmp++;
         if (base_tick !== exp_bt || tick !== exp_tick) begin
            n_fail++;
            $display("FAIL disable_per1[%0d]: got bt=%b tick=%b, want bt=%b tick=%b",
                     j, base_tick, tick, exp_bt, exp_tick);
         end
      end
      run = 1'b0;
   endtask

   task automatic test_write_collision();
      do_reset();
      cfg_write(3'd0, 16'd2);
      cfg_write(3'd1, 16'd1);
      run = 1'b1;
      for (int j = 0; j < 34; j++) begin
         logic       exp_bt;
         logic [3:0] exp_tick;
         if (j == 16) begin
            cfg_we     = 1'b1;
            cfg_ch     = 3'd0;
            cfg_period = 16'd2;
         end else begin
            cfg_we = 1'b0;
         end
         step_clk();
         exp_bt   = (j > 0) && (j % 4 == 0);
         exp_tick = {1'b0, 1'b0, exp_bt, (j == 8) || (j == 24) || (j == 32)};
         n_cmp++;
         if (base_tick !== exp_bt || tick !== exp_tick) begin
            n_fail++;
            $display("FAIL write_collision[%0d]: got bt=%b tick=%b, want bt=%b tick=%b",
                     j, base_tick, tick, exp_bt, exp_tick);
         end
      end
      cfg_we = 1'b0;
      run    = 1'b0;
   endtask

   task automatic test_ignored_index();
      do_reset();
      cfg_write(3'd0, 16'd2);
      cfg_write(3'd1, 16'd1);
      run = 1'b1;
      for (int j = 0; j < 26; j++) begin
         logic       exp_bt;
         logic [3:0] exp_tick;
         cfg_we = 1'b0;
         if (j == 8) begin
            cfg_we     = 1'b1;
            cfg_ch     = 3'd5;
            cfg_period = 16'd1;
         end else if (j == 10) begin
            cfg_we     = 1'b1;
            cfg_ch     = 3'd7;
            cfg_period = 16'd1;
         end
         step_clk();
         exp_bt   = (j > 0) && (j % 4 == 0);
         exp_tick = {1'b0, 1'b0, exp_bt, (j > 0) && (j % 8 == 0)};
         n_cmp++;
         if (base_tick !== exp_bt || tick !== exp_tick) begin
            n_fail++;
            $display("FAIL ignored_index[%0d]: got bt=%b tick=%b, want bt=%b tick=%b",
                     j, base_tick, tick, exp_bt, exp_tick);
         end
      end
      cfg_we = 1'b0;
      run    = 1'b0;
   endtask

   initial begin
      clr        = 1'b1;
      run        = 1'b0;
      step       = 1'b0;
      cfg_we     = 1'b0;
      cfg_ch     = 3'd0;
      cfg_period = '0;
      test_reset();
      test_basic_rate();
      test_pause_step();
      test_disable_period1();
      test_write_collision();
      test_ignored_index();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
